// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared encodings, tracker entry type and byte-mask table for the LSU memory controller
package lsu_mem_ctrl_pkg;

    localparam int LSU_XLEN            = 64;
    localparam int LSU_VADDR_LEN       = 32;
    localparam int LSU_LIW             = 2;
    localparam int LSU_MAX_OUTSTANDING = 4;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_D = 2'd3;

    localparam logic LSU_OP_LOAD  = 1'b0;
    localparam logic LSU_OP_STORE = 1'b1;

    // One in-flight bus beat; kill marks beats whose result must be discarded
    typedef struct packed {
        logic [LSU_LIW-1:0] lsq_index;
        logic               opcode;
        logic [1:0]         size;
        logic               sign;
        logic [2:0]         off;
        logic               kill;
    } lsu_trk_entry_t;

    // Unshifted byte enables for an access of the given size
    function automatic logic [7:0] lsu_size_mask(input logic [1:0] size);
        case (size)
            LSU_SIZE_B: return 8'h01;
            LSU_SIZE_H: return 8'h03;
            LSU_SIZE_W: return 8'h0F;
            default:    return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_inflight_fifo.sv
// rtl/lsu_inflight_fifo.sv - in-order tracker FIFO of outstanding bus beats with a parallel kill-all
module lsu_inflight_fifo
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DEPTH = LSU_MAX_OUTSTANDING
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           push,
    input  lsu_trk_entry_t wr_data,
    input  logic           pop,
    input  logic           kill_all,
    output lsu_trk_entry_t rd_data,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);

    lsu_trk_entry_t   mem [DEPTH];
    logic [DEPTH-1:0] kill_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Payload storage; needs no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and kill bits; free slots are rewritten on push, so killing every slot is safe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            kill_q <= '0;
        end else begin
            if (kill_all) begin
                kill_q <= '1;
            end
            if (do_push) begin
                kill_q[wr_ptr] <= wr_data.kill;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head entry with its live kill bit
    always_comb begin
        rd_data      = mem[rd_ptr];
        rd_data.kill = kill_q[rd_ptr];
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - LSQ to data-memory bridge: aligned beats, in-order tracking, load extraction
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int XLEN               = LSU_XLEN,
    parameter int VIRTUAL_ADDR_LEN   = LSU_VADDR_LEN,
    parameter int LSU_LSQ_SIZE_WIDTH = LSU_LIW,
    parameter int MAX_OUTSTANDING    = LSU_MAX_OUTSTANDING
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_opcode_i,
    input  logic                          req_sign_i,
    input  logic [1:0]                    req_size_i,
    input  logic [VIRTUAL_ADDR_LEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]               req_data_i,
    input  logic [LSU_LSQ_SIZE_WIDTH-1:0] req_lsq_index_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [LSU_LSQ_SIZE_WIDTH-1:0] resp_lsq_index_o,
    output logic [XLEN-1:0]               resp_data_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic                          mem_we_o,
    output logic [VIRTUAL_ADDR_LEN-1:0]   mem_addr_o,
    output logic [7:0]                    mem_wmask_o,
    output logic [XLEN-1:0]               mem_wdata_o,
    input  logic                          mem_resp_valid_i,
    output logic                          mem_resp_ready_o,
    input  logic [XLEN-1:0]               mem_rdata_i
);

    lsu_trk_entry_t                push_entry;
    lsu_trk_entry_t                head;
    logic                          trk_full;
    logic                          trk_empty;
    logic                          push;
    logic                          mem_resp_fire;
    logic                          pop_is_live_load;
    logic                          load_fire;
    logic [2:0]                    off;
    logic [XLEN-1:0]               rd_shift;
    logic [XLEN-1:0]               ext_data;
    logic                          out_valid;
    logic [LSU_LSQ_SIZE_WIDTH-1:0] out_tag;
    logic [XLEN-1:0]               out_data;

    assign off             = req_addr_i[2:0];
    assign mem_req_valid_o = rstn & req_valid_i & ~trk_full & ~flush;
    assign req_ready_o     = rstn & mem_req_ready_i & ~trk_full & ~flush;
    assign push            = req_valid_i & req_ready_o;
    assign mem_we_o        = req_opcode_i;
    assign mem_addr_o      = {req_addr_i[VIRTUAL_ADDR_LEN-1:3], 3'b000};
    assign mem_wdata_o     = req_data_i << {off, 3'b000};
    assign mem_wmask_o     = (req_opcode_i == LSU_OP_STORE) ? (lsu_size_mask(req_size_i) << off) : 8'h00;

    // Tracker entry for the beat being issued; it always enters live
    always_comb begin
        push_entry           = '0;
        push_entry.lsq_index = req_lsq_index_i;
        push_entry.opcode    = req_opcode_i;
        push_entry.size      = req_size_i;
        push_entry.sign      = req_sign_i;
        push_entry.off       = off;
        push_entry.kill      = 1'b0;
    end

    lsu_inflight_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .wr_data  (push_entry),
        .pop      (mem_resp_fire),
        .kill_all (flush),
        .rd_data  (head),
        .full     (trk_full),
        .empty    (trk_empty)
    );

    // Only a live load needs the output register; stores and killed beats always drain
    assign pop_is_live_load = ~trk_empty & ~head.kill & (head.opcode == LSU_OP_LOAD);
    assign mem_resp_ready_o = rstn & (~out_valid | resp_ready_i | ~pop_is_live_load);
    assign mem_resp_fire    = mem_resp_valid_i & mem_resp_ready_o & ~trk_empty;
    assign load_fire        = mem_resp_fire & pop_is_live_load & ~flush;

    // Byte-lane extraction and sign/zero extension of the returning beat
    always_comb begin
        rd_shift = mem_rdata_i >> {head.off, 3'b000};
        case (head.size)
            LSU_SIZE_B: ext_data = {{(XLEN-8){head.sign & rd_shift[7]}}, rd_shift[7:0]};
            LSU_SIZE_H: ext_data = {{(XLEN-16){head.sign & rd_shift[15]}}, rd_shift[15:0]};
            LSU_SIZE_W: ext_data = {{(XLEN-32){head.sign & rd_shift[31]}}, rd_shift[31:0]};
            default:    ext_data = rd_shift;
        endcase
    end

    // Response register: refill beats a drain, so back-to-back loads flow at full rate
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_fire) begin
            out_valid <= 1'b1;
            out_tag   <= head.lsq_index;
            out_data  <= ext_data;
        end else if (resp_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    assign resp_valid_o     = rstn & out_valid;
    assign resp_lsq_index_o = out_tag;
    assign resp_data_o      = out_data;

    // The bus must never return more beats than were requested
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(mem_resp_valid_i && trk_empty))
                else $error("lsu_mem_ctrl: mem response with empty tracker");
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with directed vectors
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_opcode_i = 1'b0;
    logic        req_sign_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic [31:0] req_addr_i = '0;
    logic [63:0] req_data_i = '0;
    logic [1:0]  req_lsq_index_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [1:0]  resp_lsq_index_o;
    logic [63:0] resp_data_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wmask_o;
    logic [63:0] mem_wdata_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_ready_o;
    logic [63:0] mem_rdata_i = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [65:0] exp_q[$];
    logic [63:0] mem_q[$];
    logic        mem_en = 1'b1;
    logic        mfire;
    logic [31:0] cap_addr;
    logic [7:0]  cap_mask;
    logic [63:0] cap_wdata;
    logic        cap_we;
    logic        cap_mvalid;

    lsu_mem_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_opcode_i     (req_opcode_i),
        .req_sign_i       (req_sign_i),
        .req_size_i       (req_size_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .req_lsq_index_i  (req_lsq_index_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_lsq_index_o (resp_lsq_index_o),
        .resp_data_o      (resp_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted response is matched against the scoreboard head
    initial begin
        logic [65:0] e;
        forever begin
            @(negedge clk);
            if (rstn && resp_valid_o && resp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected_valid", 64'(resp_valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_tag", 64'(resp_lsq_index_o), 64'(e[65:64]));
                    chk("resp_data", resp_data_o, e[63:0]);
                end
            end
        end
    end

    // Memory model: returns queued beats in order while enabled
    initial begin
        forever begin
            @(negedge clk);
            mfire = mem_resp_valid_i && mem_resp_ready_o;
            @(posedge clk);
            #1;
            if (mfire && mem_q.size() > 0) void'(mem_q.pop_front());
            mem_resp_valid_i = rstn && mem_en && (mem_q.size() > 0);
            mem_rdata_i      = (mem_q.size() > 0) ? mem_q[0] : 64'd0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic op, input logic sgn, input logic [1:0] size,
                         input logic [31:0] addr, input logic [63:0] data, input logic [1:0] tag,
                         input logic [63:0] rdata, input logic want_resp, input logic [63:0] exp_data);
        int  n;
        logic ok;
        @(posedge clk);
        #2;
        req_valid_i     = 1'b1;
        req_opcode_i    = op;
        req_sign_i      = sgn;
        req_size_i      = size;
        req_addr_i      = addr;
        req_data_i      = data;
        req_lsq_index_i = tag;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready_o) ok = 1'b1;
            n++;
        end
        if (!ok) chk("issue_accept_timeout", 64'(req_ready_o), 64'd1);
        cap_addr   = mem_addr_o;
        cap_mask   = mem_wmask_o;
        cap_wdata  = mem_wdata_o;
        cap_we     = mem_we_o;
        cap_mvalid = mem_req_valid_o;
        @(posedge clk);
        if (ok) begin
            mem_q.push_back(rdata);
            if (want_resp) exp_q.push_back({tag, exp_data});
        end
        #2;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size() + mem_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_resp_valid(input string name);
        int n = 0;
        while (!resp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(resp_valid_o), 64'd1);
    endtask

    initial begin
        // Reset: request held high must not leak through
        req_valid_i  = 1'b1;
        req_opcode_i = 1'b1;
        req_size_i   = 2'd3;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        @(posedge clk);
        #2;
        req_valid_i = 1'b0;
        rstn        = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("post_rst_resp_valid", 64'(resp_valid_o), 64'd0);

        // Store D aligned
        issue(1'b1, 1'b0, 2'd3, 32'h1000, 64'h1122334455667788, 2'd0, 64'd0, 1'b0, 64'd0);
        chk("st_d_mvalid", 64'(cap_mvalid), 64'd1);
        chk("st_d_we", 64'(cap_we), 64'd1);
        chk("st_d_addr", 64'(cap_addr), 64'h1000);
        chk("st_d_mask", 64'(cap_mask), 64'hFF);
        chk("st_d_wdata", cap_wdata, 64'h1122334455667788);
        wait_drain("st_d_drain");

        // Byte loads: lane 2 holds 0xFF, lane 3 holds 0x80
        issue(1'b0, 1'b1, 2'd0, 32'h1002, 64'd0, 2'd1, 64'h0000000080FF0000, 1'b1, 64'hFFFFFFFFFFFFFFFF);
        chk("ld_b_mask", 64'(cap_mask), 64'h00);
        chk("ld_b_we", 64'(cap_we), 64'd0);
        issue(1'b0, 1'b0, 2'd0, 32'h1002, 64'd0, 2'd2, 64'h0000000080FF0000, 1'b1, 64'h00000000000000FF);
        issue(1'b0, 1'b1, 2'd0, 32'h1003, 64'd0, 2'd3, 64'h0000000080FF0000, 1'b1, 64'hFFFFFFFFFFFFFF80);
        chk("ld_b_addr", 64'(cap_addr), 64'h1000);
        issue(1'b0, 1'b0, 2'd0, 32'h1003, 64'd0, 2'd0, 64'h0000000080FF0000, 1'b1, 64'h0000000000000080);
        wait_drain("ld_b_drain");

        // Halfword store in the top lanes, word and halfword loads
        issue(1'b1, 1'b0, 2'd1, 32'h2006, 64'h000000000000ABCD, 2'd1, 64'd0, 1'b0, 64'd0);
        chk("st_h_addr", 64'(cap_addr), 64'h2000);
        chk("st_h_mask", 64'(cap_mask), 64'hC0);
        chk("st_h_wdata", cap_wdata, 64'hABCD000000000000);
        issue(1'b0, 1'b1, 2'd2, 32'h2004, 64'd0, 2'd3, 64'h8000000100000000, 1'b1, 64'hFFFFFFFF80000001);
        chk("ld_w_addr", 64'(cap_addr), 64'h2000);
        issue(1'b0, 1'b1, 2'd1, 32'h2002, 64'd0, 2'd2, 64'h0000000092340000, 1'b1, 64'hFFFFFFFFFFFF9234);
        issue(1'b0, 1'b0, 2'd1, 32'h2002, 64'd0, 2'd1, 64'h0000000092340000, 1'b1, 64'h0000000000009234);
        wait_drain("st_h_drain");

        // Fill the tracker, back-pressure the response side, drain in order
        @(posedge clk);
        #2;
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, 2'd3, 32'h3000 + 32'(8 * i), 64'd0, 2'(i),
                  64'h0123456789ABCDE0 + 64'(i), 1'b1, 64'h0123456789ABCDE0 + 64'(i));
        end
        @(posedge clk);
        #2;
        req_valid_i  = 1'b1;
        req_opcode_i = 1'b0;
        @(negedge clk);
        chk("full_req_ready", 64'(req_ready_o), 64'd0);
        chk("full_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        @(posedge clk);
        #2;
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b0;
        mem_en       = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_resp_valid", 64'(resp_valid_o), 64'd1);
        chk("bp_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        repeat (2) @(negedge clk);
        chk("bp_mem_resp_ready_hold", 64'(mem_resp_ready_o), 64'd0);
        @(posedge clk);
        #2;
        resp_ready_i = 1'b1;
        wait_drain("full_drain");

        // Flush with a held response and three loads outstanding
        @(posedge clk);
        #2;
        resp_ready_i = 1'b0;
        issue(1'b0, 1'b0, 2'd3, 32'h4000, 64'd0, 2'd0, 64'h5555555555555555, 1'b0, 64'd0);
        wait_resp_valid("fl_pre_valid");
        @(posedge clk);
        #2;
        mem_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            issue(1'b0, 1'b0, 2'd3, 32'h4000 + 32'(8 * i), 64'd0, 2'(i), 64'hDEAD0000 + 64'(i), 1'b0, 64'd0);
        end
        @(posedge clk);
        #2;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_req_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_resp_valid", 64'(resp_valid_o), 64'd0);
        @(posedge clk);
        #2;
        resp_ready_i = 1'b1;
        mem_en       = 1'b1;
        wait_drain("fl_discard_drain");
        issue(1'b0, 1'b1, 2'd2, 32'h4010, 64'd0, 2'd2, 64'h000000007FFFFFFF, 1'b1, 64'h000000007FFFFFFF);
        wait_drain("fl_after_drain");

        // Reset with loads in flight and a held response
        @(posedge clk);
        #2;
        resp_ready_i = 1'b0;
        issue(1'b0, 1'b0, 2'd3, 32'h5000, 64'd0, 2'd1, 64'h7777777777777777, 1'b0, 64'd0);
        wait_resp_valid("rs_pre_valid");
        @(posedge clk);
        #2;
        mem_en = 1'b0;
        issue(1'b0, 1'b0, 2'd3, 32'h5008, 64'd0, 2'd2, 64'h1, 1'b0, 64'd0);
        issue(1'b0, 1'b0, 2'd3, 32'h5010, 64'd0, 2'd3, 64'h2, 1'b0, 64'd0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        mem_q.delete();
        @(negedge clk);
        chk("rs_in_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rs_in_req_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #2;
        rstn            = 1'b1;
        mem_req_ready_i = 1'b0;
        @(negedge clk);
        chk("rs_out_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rs_out_req_ready_lo", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #2;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        chk("rs_out_req_ready_hi", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #2;
        resp_ready_i = 1'b1;
        mem_en       = 1'b1;
        issue(1'b0, 1'b1, 2'd0, 32'h5007, 64'd0, 2'd3, 64'h8100000000000000, 1'b1, 64'hFFFFFFFFFFFFFF81);
        wait_drain("rs_after_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
